vend_sequencer: RTL

- Controller for the vending coin/credit datapath.
- Holds the customer credit and accepts coins into it.
- Arbitrates purchase requests from two buyer panels (A, B) using round-robin.
- Sequences item dispense over a valid/ready handshake, and returns change coin-by-coin over a second valid/ready handshake when a refund is requested.

---
 rtl/vend_pkg.sv | 53 +++++
 rtl/vend_rr_arb.sv | 25 ++
 rtl/vend_sequencer.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/vend_pkg.sv
// Shared types, coin/item encodings and credit helpers for the vending sequencer.
package vend_pkg;

  localparam int unsigned CRED_W = 4;
  localparam int unsigned SUM_W  = 5;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    VEND   = 2'd1,
    CHANGE = 2'd2
  } state_e;

  localparam logic [1:0] COIN_NONE = 2'b00;
  localparam logic [1:0] COIN_1    = 2'b01;
  localparam logic [1:0] COIN_3    = 2'b10;
  localparam logic [1:0] COIN_10   = 2'b11;

  localparam logic [SUM_W-1:0] VAL_1  = SUM_W'(1);
  localparam logic [SUM_W-1:0] VAL_3  = SUM_W'(3);
  localparam logic [SUM_W-1:0] VAL_10 = SUM_W'(10);

  localparam logic [1:0] ITEM_NONE = 2'b00;
  localparam logic [1:0] ITEM_1    = 2'b01;
  localparam logic [1:0] ITEM_2    = 2'b10;
  localparam logic [1:0] ITEM_3    = 2'b11;

  // One buyer panel's request as presented at the controller boundary.
  typedef struct packed {
    logic       req;
    logic [1:0] item;
  } buy_req_t;

  function automatic logic [SUM_W-1:0] coin_value(input logic [1:0] coin);
    logic [SUM_W-1:0] v;
    case (coin)
      COIN_1:  v = VAL_1;
      COIN_3:  v = VAL_3;
      COIN_10: v = VAL_10;
      default: v = '0;
    endcase
    return v;
  endfunction

  // Largest coin that does not exceed the remaining credit.
  function automatic logic [1:0] change_coin(input logic [CRED_W-1:0] amt);
    logic [1:0] c;
    if (SUM_W'(amt) >= VAL_10)     c = COIN_10;
    else if (SUM_W'(amt) >= VAL_3) c = COIN_3;
    else                           c = COIN_1;
    return c;
  endfunction

endpackage

// File: rtl/vend_rr_arb.sv
// Two-way round-robin arbiter: bit 0 is panel A, bit 1 is panel B; ptr 0 favours A.
module vend_rr_arb (
  input  logic [1:0] req,
  input  logic       ptr,
  output logic [1:0] gnt_c,
  output logic       ptr_nxt_c
);

  always_comb begin
    gnt_c     = 2'b00;
    ptr_nxt_c = ptr;
    if (req == 2'b11) begin
      gnt_c = ptr ? 2'b10 : 2'b01;
    end else begin
      gnt_c = req;
    end
    // The panel just served loses priority next time.
    if (gnt_c[0]) begin
      ptr_nxt_c = 1'b1;
    end else if (gnt_c[1]) begin
      ptr_nxt_c = 1'b0;
    end
  end

endmodule

// File: rtl/vend_sequencer.sv
// Vending controller: credit accumulation, round-robin purchase arbitration,
// item dispense handshake and greedy coin-by-coin change return.
module vend_sequencer
  import vend_pkg::*;
#(
  parameter int unsigned CREDIT_MAX = 15,
  parameter int unsigned PRICE_1    = 5,
  parameter int unsigned PRICE_2    = 10,
  parameter int unsigned PRICE_3    = 15
) (
  input  logic              clk,
  input  logic              clr_n,
  input  logic [1:0]        coin_type,
  input  logic              req_a,
  input  logic [1:0]        req_type_a,
  input  logic              req_b,
  input  logic [1:0]        req_type_b,
  input  logic              refund,
  input  logic              vend_ready,
  input  logic              coin_out_ready,
  output logic              gnt_a,
  output logic              gnt_b,
  output logic              deny,
  output logic              vend_valid,
  output logic [1:0]        vend_type,
  output logic              coin_out_valid,
  output logic [1:0]        coin_out_type,
  output logic              coin_reject,
  output logic [CRED_W-1:0] credit,
  output logic              busy
);

  state_e            state_q, state_d;
  logic              ptr_q, ptr_d;
  logic [CRED_W-1:0] credit_d;
  logic              gnt_a_d, gnt_b_d, deny_d, coin_reject_d;
  logic              vend_valid_d, coin_out_valid_d;
  logic [1:0]        vend_type_d, coin_out_type_d;

  buy_req_t          pan_a_c, pan_b_c;
  logic [1:0]        req_vld_c, arb_gnt_c;
  logic              arb_ptr_c;
  logic [1:0]        sel_type_c;
  logic [SUM_W-1:0]  price_c, add_c, sub_c, sum_c;

  function automatic logic [SUM_W-1:0] item_price(input logic [1:0] item);
    logic [SUM_W-1:0] p;
    case (item)
      ITEM_1:  p = SUM_W'(PRICE_1);
      ITEM_2:  p = SUM_W'(PRICE_2);
      ITEM_3:  p = SUM_W'(PRICE_3);
      default: p = '0;
    endcase
    return p;
  endfunction

  assign pan_a_c = '{req: req_a, item: req_type_a};
  assign pan_b_c = '{req: req_b, item: req_type_b};

  // A request still high while its own grant pulses is the one just consumed.
  assign req_vld_c[0] = pan_a_c.req && (pan_a_c.item != ITEM_NONE) && !gnt_a;
  assign req_vld_c[1] = pan_b_c.req && (pan_b_c.item != ITEM_NONE) && !gnt_b;

  vend_rr_arb u_arb (
    .req       (req_vld_c),
    .ptr       (ptr_q),
    .gnt_c     (arb_gnt_c),
    .ptr_nxt_c (arb_ptr_c)
  );

  assign sel_type_c = arb_gnt_c[1] ? pan_b_c.item : pan_a_c.item;
  assign price_c    = item_price(sel_type_c);

  // Next state, credit and registered-output values.
  always_comb begin
    state_d          = state_q;
    ptr_d            = ptr_q;
    gnt_a_d          = 1'b0;
    gnt_b_d          = 1'b0;
    deny_d           = 1'b0;
    coin_reject_d    = 1'b0;
    vend_valid_d     = vend_valid;
    vend_type_d      = vend_type;
    coin_out_valid_d = coin_out_valid;
    coin_out_type_d  = coin_out_type;
    add_c            = coin_value(coin_type);
    sub_c            = '0;

    case (state_q)
      IDLE: begin
        if (refund && (credit != '0)) begin
          state_d          = CHANGE;
          coin_out_valid_d = 1'b1;
        end else if (|arb_gnt_c) begin
          ptr_d   = arb_ptr_c;
          gnt_a_d = arb_gnt_c[0];
          gnt_b_d = arb_gnt_c[1];
          if (SUM_W'(credit) >= price_c) begin
            sub_c        = price_c;
            vend_valid_d = 1'b1;
            vend_type_d  = sel_type_c;
            state_d      = VEND;
          end else begin
            deny_d = 1'b1;
          end
        end
      end
      VEND: begin
        if (vend_ready) begin
          vend_valid_d = 1'b0;
          state_d      = IDLE;
        end
      end
      CHANGE: begin
        add_c         = '0;
        coin_reject_d = (coin_type != COIN_NONE);
        if (coin_out_valid && coin_out_ready) begin
          sub_c = coin_value(coin_out_type);
        end
      end
      default: state_d = IDLE;
    endcase

    // Change coins never exceed credit, so the 5-bit difference cannot underflow.
    sum_c    = SUM_W'(credit) - sub_c + add_c;
    credit_d = (sum_c > SUM_W'(CREDIT_MAX)) ? CRED_W'(CREDIT_MAX) : CRED_W'(sum_c);

    if ((state_q == CHANGE) && coin_out_valid && coin_out_ready && (credit_d == '0)) begin
      coin_out_valid_d = 1'b0;
      state_d          = IDLE;
    end
    if (state_d == CHANGE) begin
      coin_out_type_d = change_coin(credit_d);
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q        <= IDLE;
      ptr_q          <= 1'b0;
      credit         <= '0;
      gnt_a          <= 1'b0;
      gnt_b          <= 1'b0;
      deny           <= 1'b0;
      vend_valid     <= 1'b0;
      vend_type      <= 2'b00;
      coin_out_valid <= 1'b0;
      coin_out_type  <= 2'b00;
      coin_reject    <= 1'b0;
      busy           <= 1'b0;
    end else begin
      state_q        <= state_d;
      ptr_q          <= ptr_d;
      credit         <= credit_d;
      gnt_a          <= gnt_a_d;
      gnt_b          <= gnt_b_d;
      deny           <= deny_d;
      vend_valid     <= vend_valid_d;
      vend_type      <= vend_type_d;
      coin_out_valid <= coin_out_valid_d;
      coin_out_type  <= coin_out_type_d;
      coin_reject    <= coin_reject_d;
      busy           <= (state_d != IDLE);
    end
  end

endmodule
